// File: rtl/alu_rv_pkg.sv
// Shared definitions for the rv U-type execution unit: op encodings,
// default datapath width and the U-type immediate expansion.
package alu_rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        UI_OP_LUI   = 1'b0,
        UI_OP_AUIPC = 1'b1
    } ui_op_e;

    // Returns {imm20, 12'b0} sign-extended to xlen bits, zero above xlen.
    function automatic logic [63:0] u_imm_extend(input logic [19:0] imm20, input int xlen);
        logic [63:0] ext;
        ext = {{32{imm20[19]}}, imm20, 12'h000};
        if (xlen == 32) begin
            ext[63:32] = '0;
        end
        return ext;
    endfunction

endpackage

// File: rtl/alu_upper_immediate_unit_if.sv
// Valid/ready bundle between decode, the U-type unit and writeback.
interface alu_upper_immediate_unit_if
    import alu_rv_pkg::*;
#(
    parameter int XLEN          = XLEN_DEFAULT,
    parameter int RD_ADDR_WIDTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_op;
    logic [19:0]              in_imm20;
    logic [XLEN-1:0]          in_pc;
    logic [RD_ADDR_WIDTH-1:0] in_rd;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_rd_value;
    logic [RD_ADDR_WIDTH-1:0] out_rd;

    modport master (
        output in_valid, in_op, in_imm20, in_pc, in_rd, out_ready,
        input  in_ready, out_valid, out_rd_value, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_imm20, in_pc, in_rd, out_ready,
        output in_ready, out_valid, out_rd_value, out_rd
    );
endinterface

// File: rtl/alu_rv_pipe_stage.sv
// One valid/ready register slice; loads when empty or draining this cycle,
// and drops its contents on flush.
module alu_rv_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    // Nothing is accepted during flush, so a flushed stage also blocks its upstream.
    assign o_ready = !flush && (!r_valid || i_ready);
    assign w_load  = i_valid && o_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            // NOTE: the payload is reset as well, so no X can reach the result bus.
            r_data  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (o_ready) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/alu_upper_immediate_unit.sv
// U-type execution unit (LUI/AUIPC) with a 1- or 2-stage valid/ready pipeline.
// Define ALU_UPPER_IMMEDIATE_PERF_EN to add saturating LUI/AUIPC output counters.
module alu_upper_immediate_unit
    import alu_rv_pkg::*;
#(
    parameter int XLEN          = XLEN_DEFAULT,
    parameter int PIPE_STAGES   = 1,
    parameter int RD_ADDR_WIDTH = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  logic flush,
    alu_upper_immediate_unit_if.slave io_bus
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    ,
    output logic [31:0] perf_lui_count,
    output logic [31:0] perf_auipc_count
`endif
);
    localparam int S1_W = 1 + 2 * XLEN + RD_ADDR_WIDTH;

    logic [S1_W-1:0]          w_s1_in;
    logic [S1_W-1:0]          w_s1_out;
    logic                     w_s1_ready;
    logic                     w_s1_valid;
    logic                     w_s1_down_ready;
    logic                     w_s1_op;
    logic [XLEN-1:0]          w_imm;
    logic [XLEN-1:0]          w_s1_imm;
    logic [XLEN-1:0]          w_s1_pc;
    logic [RD_ADDR_WIDTH-1:0] w_s1_rd;
    logic [XLEN-1:0]          w_sum;
    logic [XLEN-1:0]          w_result;
    logic                     w_out_valid;
    logic [XLEN-1:0]          w_out_value;
    logic [RD_ADDR_WIDTH-1:0] w_out_rd;

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    logic        w_out_op;
    logic        w_out_fire;
    logic [31:0] r_perf_lui_count;
    logic [31:0] r_perf_auipc_count;
`endif

    assign w_imm   = XLEN'(u_imm_extend(io_bus.in_imm20, XLEN));
    assign w_s1_in = {io_bus.in_op, w_imm, io_bus.in_pc, io_bus.in_rd};

    alu_rv_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .i_valid (io_bus.in_valid),
        .o_ready (w_s1_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s1_down_ready),
        .o_data  (w_s1_out)
    );

    assign {w_s1_op, w_s1_imm, w_s1_pc, w_s1_rd} = w_s1_out;

    // x0 is forced to zero here so the bus never shows a nonzero x0 write.
    assign w_sum    = w_s1_pc + w_s1_imm;
    assign w_result = (w_s1_rd == '0)          ? '0    :
                      (w_s1_op == UI_OP_AUIPC) ? w_sum : w_s1_imm;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
            localparam int S2_W = XLEN + RD_ADDR_WIDTH + 1;
`else
            localparam int S2_W = XLEN + RD_ADDR_WIDTH;
`endif
            logic [S2_W-1:0] w_s2_in;
            logic [S2_W-1:0] w_s2_out;

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
            assign w_s2_in  = {w_s1_op, w_result, w_s1_rd};
            assign w_out_op = w_s2_out[S2_W-1];
`else
            assign w_s2_in  = {w_result, w_s1_rd};
`endif

            alu_rv_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
                .clock   (clock),
                .reset_n (reset_n),
                .flush   (flush),
                .i_valid (w_s1_valid),
                .o_ready (w_s1_down_ready),
                .i_data  (w_s2_in),
                .o_valid (w_out_valid),
                .i_ready (io_bus.out_ready),
                .o_data  (w_s2_out)
            );

            assign {w_out_value, w_out_rd} = w_s2_out[XLEN+RD_ADDR_WIDTH-1:0];
        end else begin : g_one_stage
            assign w_s1_down_ready = io_bus.out_ready;
            assign w_out_valid     = w_s1_valid;
            assign w_out_value     = w_result;
            assign w_out_rd        = w_s1_rd;
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
            assign w_out_op        = w_s1_op;
`endif
        end
    endgenerate

    // Ready is held low for the whole time reset is asserted.
    assign io_bus.in_ready     = reset_n && w_s1_ready;
    assign io_bus.out_valid    = w_out_valid;
    assign io_bus.out_rd_value = w_out_valid ? w_out_value : '0;
    assign io_bus.out_rd       = w_out_rd;

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    assign w_out_fire = w_out_valid && io_bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_lui_count   <= '0;
            r_perf_auipc_count <= '0;
        end else if (w_out_fire) begin
            if (w_out_op == UI_OP_AUIPC) begin
                if (r_perf_auipc_count != 32'hFFFF_FFFF) begin
                    r_perf_auipc_count <= r_perf_auipc_count + 32'd1;
                end
            end else if (r_perf_lui_count != 32'hFFFF_FFFF) begin
                r_perf_lui_count <= r_perf_lui_count + 32'd1;
            end
        end
    end

    assign perf_lui_count   = r_perf_lui_count;
    assign perf_auipc_count = r_perf_auipc_count;
`endif
endmodule

// File: tb/tb_alu_upper_immediate_unit.sv
// Bench for alu_upper_immediate_unit: unit A (XLEN 32, 1 stage) and unit B
// (XLEN 64, 2 stages) run side by side against a queue-based reference model.
module tb_alu_upper_immediate_unit;

    typedef struct {
        logic [63:0] value;
        logic [4:0]  rd;
        bit          op;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q [2][$];
    int   n_out   [2];
    int   n_lui   [2];
    int   n_auipc [2];

    alu_upper_immediate_unit_if #(.XLEN(32), .RD_ADDR_WIDTH(5)) bus_a ();
    alu_upper_immediate_unit_if #(.XLEN(64), .RD_ADDR_WIDTH(5)) bus_b ();

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
    logic [31:0] perf_lui_a, perf_auipc_a, perf_lui_b, perf_auipc_b;
`endif

    alu_upper_immediate_unit #(.XLEN(32), .PIPE_STAGES(1), .RD_ADDR_WIDTH(5)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .io_bus  (bus_a)
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        ,
        .perf_lui_count   (perf_lui_a),
        .perf_auipc_count (perf_auipc_a)
`endif
    );

    alu_upper_immediate_unit #(.XLEN(64), .PIPE_STAGES(2), .RD_ADDR_WIDTH(5)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .io_bus  (bus_b)
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        ,
        .perf_lui_count   (perf_lui_b),
        .perf_auipc_count (perf_auipc_b)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: result from the U-type rules using plain integer arithmetic.
    function automatic logic [63:0] ref_result(input int xlen, input bit op,
                                               input logic [19:0] imm20,
                                               input logic [63:0] pc,
                                               input logic [4:0] rd);
        longint signed imm;
        logic [63:0]   r;
        imm = longint'($signed({imm20, 12'h000}));
        r   = op ? (pc + 64'(imm)) : 64'(imm);
        if (rd == 5'd0) r = 64'd0;
        if (xlen == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    task automatic clear_model();
        for (int u = 0; u < 2; u++) begin
            q[u].delete();
            n_lui[u]   = 0;
            n_auipc[u] = 0;
        end
    endtask

    task automatic observe(input int u, input int xlen, input logic ov, input logic ordy,
                           input logic [63:0] val, input logic [4:0] ord,
                           input logic iv, input logic irdy, input logic op,
                           input logic [19:0] imm20, input logic [63:0] pc,
                           input logic [4:0] ird);
        string s;
        exp_t  e;
        s = (u == 0) ? "a" : "b";
        if (ov && ordy) begin
            if (q[u].size() == 0) begin
                check({s, "_unexpected_output"}, 64'(ov), 64'd0);
            end else begin
                e = q[u].pop_front();
                check({s, "_out_value"}, val, e.value);
                check({s, "_out_rd"}, 64'(ord), 64'(e.rd));
                n_out[u]++;
                if (e.op) n_auipc[u]++;
                else n_lui[u]++;
            end
        end else if (!ov) begin
            check({s, "_idle_value_zero"}, val, 64'd0);
        end
        if (flush) begin
            check({s, "_in_ready_during_flush"}, 64'(irdy), 64'd0);
            q[u].delete();
        end else if (iv && irdy) begin
            q[u].push_back('{value: ref_result(xlen, op, imm20, pc, ird), rd: ird, op: op});
        end
    endtask

    always @(negedge reset_n) clear_model();

    always @(negedge clock) begin
        if (!reset_n) begin
            clear_model();
        end else begin
            observe(0, 32, bus_a.out_valid, bus_a.out_ready, 64'(bus_a.out_rd_value), bus_a.out_rd,
                    bus_a.in_valid, bus_a.in_ready, bus_a.in_op, bus_a.in_imm20,
                    64'(bus_a.in_pc), bus_a.in_rd);
            observe(1, 64, bus_b.out_valid, bus_b.out_ready, bus_b.out_rd_value, bus_b.out_rd,
                    bus_b.in_valid, bus_b.in_ready, bus_b.in_op, bus_b.in_imm20,
                    bus_b.in_pc, bus_b.in_rd);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic iv, input logic op, input logic [19:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd);
        bus_a.in_valid = iv; bus_a.in_op = op; bus_a.in_imm20 = imm;
        bus_a.in_pc = pc; bus_a.in_rd = rd;
    endtask

    task automatic set_b(input logic iv, input logic op, input logic [19:0] imm,
                         input logic [63:0] pc, input logic [4:0] rd);
        bus_b.in_valid = iv; bus_b.in_op = op; bus_b.in_imm20 = imm;
        bus_b.in_pc = pc; bus_b.in_rd = rd;
    endtask

    // One op into each unit; checks latency 1 on A and 2 on B against fixed values.
    task automatic directed(input string tag, input logic op, input logic [4:0] rd,
                            input logic [19:0] imm_a, input logic [31:0] pc_a, input logic [31:0] exp_a,
                            input logic [19:0] imm_b, input logic [63:0] pc_b, input logic [63:0] exp_b);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        set_a(1'b1, op, imm_a, pc_a, rd);
        set_b(1'b1, op, imm_b, pc_b, rd);
        @(negedge clock);
        check({tag, "_a_in_ready"}, 64'(bus_a.in_ready), 64'd1);
        check({tag, "_b_in_ready"}, 64'(bus_b.in_ready), 64'd1);
        tick();
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        @(negedge clock);
        check({tag, "_a_out_valid"}, 64'(bus_a.out_valid), 64'd1);
        check({tag, "_a_value"}, 64'(bus_a.out_rd_value), 64'(exp_a));
        check({tag, "_a_rd"}, 64'(bus_a.out_rd), 64'(rd));
        check({tag, "_b_not_yet_valid"}, 64'(bus_b.out_valid), 64'd0);
        tick();
        @(negedge clock);
        check({tag, "_b_out_valid"}, 64'(bus_b.out_valid), 64'd1);
        check({tag, "_b_value"}, bus_b.out_rd_value, exp_b);
        check({tag, "_b_rd"}, 64'(bus_b.out_rd), 64'(rd));
        check({tag, "_a_done"}, 64'(bus_a.out_valid), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] bp_imm [3];
        logic [63:0] bp_pc  [3];
        logic [4:0]  bp_rd  [3];
        logic        bp_op  [3];
        int          accepted;
        int          out_start;
        bit          got;

        reset_n = 1'b0;
        flush   = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        set_a(1'b0, 1'b0, 20'h0, 32'h0, 5'd0);
        set_b(1'b0, 1'b0, 20'h0, 64'h0, 5'd0);

        // Reset state
        #2;
        check("rst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_a_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst_a_value", 64'(bus_a.out_rd_value), 64'd0);
        check("rst_a_rd", 64'(bus_a.out_rd), 64'd0);
        check("rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
        check("rst_b_in_ready", 64'(bus_b.in_ready), 64'd0);
        check("rst_b_value", bus_b.out_rd_value, 64'd0);
        #10;
        reset_n = 1'b1;
        #1;
        check("post_rst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("post_rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
        tick();

        // Directed values
        directed("lui", 1'b0, 5'd3, 20'h12345, 32'h0, 32'h1234_5000,
                 20'h12345, 64'h0, 64'h0000_0000_1234_5000);
        directed("auipc_wrap", 1'b1, 5'd7, 20'h00002, 32'hFFFF_F000, 32'h0000_1000,
                 20'h80000, 64'h1000, 64'hFFFF_FFFF_8000_1000);
        directed("rd_zero", 1'b1, 5'd0, 20'h00001, 32'h100, 32'h0,
                 20'h00001, 64'h100, 64'h0);
        directed("lui_neg", 1'b0, 5'd31, 20'h80000, 32'hDEAD_BEEF, 32'h8000_0000,
                 20'h80000, 64'h1234, 64'hFFFF_FFFF_8000_0000);

        // Backpressure on the 2-stage unit: three ops, output stalled for 4 cycles
        bp_op[0] = 1'b1; bp_imm[0] = 20'h00001; bp_pc[0] = 64'h10;   bp_rd[0] = 5'd1;
        bp_op[1] = 1'b0; bp_imm[1] = 20'hABCDE; bp_pc[1] = 64'h0;    bp_rd[1] = 5'd2;
        bp_op[2] = 1'b1; bp_imm[2] = 20'hFFFFF; bp_pc[2] = 64'h2000; bp_rd[2] = 5'd4;
        out_start = n_out[1];
        accepted  = 0;
        bus_b.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_b(1'b1, bp_op[accepted], bp_imm[accepted], bp_pc[accepted], bp_rd[accepted]);
            @(negedge clock);
            if (c >= 2) begin
                check("bp_out_valid_held", 64'(bus_b.out_valid), 64'd1);
                check("bp_value_stable", bus_b.out_rd_value, 64'h1010);
                check("bp_rd_stable", 64'(bus_b.out_rd), 64'd1);
            end
            if (bus_b.in_ready) accepted++;
            tick();
        end
        check("bp_accepted_before_full", 64'(accepted), 64'd2);
        @(negedge clock);
        check("bp_in_ready_full", 64'(bus_b.in_ready), 64'd0);
        tick();
        bus_b.out_ready = 1'b1;
        set_b(1'b1, bp_op[2], bp_imm[2], bp_pc[2], bp_rd[2]);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus_b.in_ready) got = 1'b1;
            tick();
            if (got) break;
        end
        check("bp_third_accepted", 64'(got), 64'd1);
        bus_b.in_valid = 1'b0;
        for (int c = 0; c < 10 && q[1].size() != 0; c++) tick();
        check("bp_all_emerged", 64'(n_out[1] - out_start), 64'd3);

        // Flush with ops in flight and a new op offered
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        set_a(1'b1, 1'b0, 20'h11111, 32'h0, 5'd5);
        set_b(1'b1, 1'b0, 20'h11111, 64'h0, 5'd5);
        tick();
        set_a(1'b1, 1'b1, 20'h22222, 32'h40, 5'd6);
        set_b(1'b1, 1'b1, 20'h22222, 64'h40, 5'd6);
        tick();
        flush = 1'b1;
        set_a(1'b1, 1'b0, 20'h33333, 32'h0, 5'd7);
        set_b(1'b1, 1'b0, 20'h33333, 64'h0, 5'd7);
        @(negedge clock);
        check("flush_a_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("flush_b_in_ready", 64'(bus_b.in_ready), 64'd0);
        check("flush_b_in_flight", 64'(bus_b.out_valid), 64'd1);
        tick();
        flush = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("flush_a_nothing_out", 64'(bus_a.out_valid), 64'd0);
            check("flush_b_nothing_out", 64'(bus_b.out_valid), 64'd0);
            tick();
        end

        // Randomised stream with occasional flush
        for (int c = 0; c < 300; c++) begin
            flush = ($urandom_range(0, 19) == 0);
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            bus_b.out_ready = ($urandom_range(0, 3) != 0);
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 20'($urandom),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_F000 : $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 20'($urandom),
                  ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_F000 : {$urandom, $urandom},
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
            tick();
        end
        flush = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int c = 0; c < 10 && (q[0].size() != 0 || q[1].size() != 0); c++) tick();
        check("rand_a_drained", 64'(q[0].size()), 64'd0);
        check("rand_b_drained", 64'(q[1].size()), 64'd0);

`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        check("perf_a_lui", 64'(perf_lui_a), 64'(n_lui[0]));
        check("perf_a_auipc", 64'(perf_auipc_a), 64'(n_auipc[0]));
        check("perf_b_lui", 64'(perf_lui_b), 64'(n_lui[1]));
        check("perf_b_auipc", 64'(perf_auipc_b), 64'(n_auipc[1]));
`endif

        // Asynchronous reset with operations in flight
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        set_a(1'b1, 1'b0, 20'h54321, 32'h0, 5'd9);
        set_b(1'b1, 1'b0, 20'h54321, 64'h0, 5'd9);
        tick();
        tick();
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_a_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("async_rst_a_value", 64'(bus_a.out_rd_value), 64'd0);
        check("async_rst_a_rd", 64'(bus_a.out_rd), 64'd0);
        check("async_rst_a_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("async_rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
        check("async_rst_b_value", bus_b.out_rd_value, 64'd0);
        check("async_rst_b_rd", 64'(bus_b.out_rd), 64'd0);
        check("async_rst_b_in_ready", 64'(bus_b.in_ready), 64'd0);
`ifdef ALU_UPPER_IMMEDIATE_PERF_EN
        check("async_rst_perf_a", 64'(perf_lui_a) + 64'(perf_auipc_a), 64'd0);
        check("async_rst_perf_b", 64'(perf_lui_b) + 64'(perf_auipc_b), 64'd0);
`endif
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        check("rerelease_a_in_ready", 64'(bus_a.in_ready), 64'd1);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clock);
            check("lost_a_no_output", 64'(bus_a.out_valid), 64'd0);
            check("lost_b_no_output", 64'(bus_b.out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_upper_immediate_unit.md
Name: alu_upper_immediate_unit

Overview:
Parametrised U-type execution unit for the rv core; executes both LUI and AUIPC.
Sits after decode with a valid/ready handshake on both sides, replacing the enable/high-impedance scheme with explicit valid signalling.
Configurable datapath width and pipeline depth, plus a pipeline flush for branch redirect.

Parameters:
XLEN, 32, datapath/PC width; legal values 32 or 64.
PIPE_STAGES, 1, register stages from input to output; legal values 1 or 2.
RD_ADDR_WIDTH, 5, destination register index width.

Ports:
clock  input  1  single clock domain; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous; kills all in-flight operations.
in_valid  input  1  upstream holds a valid operation.
in_ready  output  1  unit accepts an operation this cycle.
in_op  input  1  0 = LUI, 1 = AUIPC.
in_imm20  input  20  U-type immediate, instruction bits 31..12.
in_pc  input  XLEN  PC of the instruction.
in_rd  input  RD_ADDR_WIDTH  destination register index.
out_valid  output  1  result available.
out_ready  input  1  downstream (writeback) accepts the result.
out_rd_value  output  XLEN  result.
out_rd  output  RD_ADDR_WIDTH  destination index, carried with the result.

Behaviour:
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Immediate: imm = {in_imm20, 12'b0}, sign-extended from bit 31 to XLEN.
- Result:
  - LUI: imm.
  - AUIPC: (in_pc + imm) mod 2^XLEN. Wrap-around is silent; no carry or overflow output.
- If in_rd == 0, out_rd_value = 0 (x0 is never nonzero on the bus).
- Stage 1 registers op, imm, pc and rd.
  - PIPE_STAGES = 1: the adder sits on the stage 1 register output.
  - PIPE_STAGES = 2: stage 2 registers the sum.
- Latency: exactly PIPE_STAGES cycles from input transfer to out_valid when the unit is unstalled.
- Throughput: one operation per cycle.
- Each stage has a valid bit. A stage loads when it is empty or when its contents move on in the same cycle.
  - in_ready = !stage1_valid || stage1_advance; combinational path from out_ready.
- Backpressure: while out_valid && !out_ready, out_rd_value and out_rd hold stable. With PIPE_STAGES = 2, a second operation may sit in stage 1; the pipeline is full and in_ready = 0.
- flush:
  - At the next posedge all stage valids clear.
  - in_ready = 0 while flush is high, so any in_valid during flush is dropped.
  - An output handshake in the flush cycle still completes.
- Reset (reset_n low, asynchronous):
  - All valids, data registers, out_rd_value and out_rd go to 0.
  - out_valid = 0 and in_ready = 0 while reset is asserted; in_ready = 1 from the first cycle after release.
- Reset mid-operation: in-flight operations are lost without any output.
- Simultaneous input and output transfers on a full pipeline are legal and keep throughput at one per cycle.
- No X on outputs after reset; out_rd_value is don't-care only while out_valid = 0, and is driven 0 in that case.

Optional Feature:
ALU_UPPER_IMMEDIATE_PERF_EN.
- Defined:
  - Adds outputs perf_lui_count [31:0] and perf_auipc_count [31:0].
  - Each counter increments on an output transfer of its op type and saturates at 32'hFFFF_FFFF.
  - Both counters clear on reset; they are not cleared by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_rv_pkg contains:
  - XLEN default.
  - Op encodings UI_OP_LUI = 1'b0 and UI_OP_AUIPC = 1'b1.
  - Function u_imm_extend(imm20, xlen).
- Sub-module alu_rv_pipe_stage: one valid/ready register slice with a payload-width parameter and flush input. It is instantiated PIPE_STAGES times.

Test Plan:
- LUI, XLEN = 32, PIPE_STAGES = 1: imm20 = 20'h12345, rd = 3 -> out_valid one cycle later, out_rd_value = 32'h12345000, out_rd = 3.
- AUIPC wrap: pc = 32'hFFFF_F000, imm20 = 20'h00002 -> 32'h0000_1000. XLEN = 64 with imm20 = 20'h80000, pc = 64'h1000 -> 64'hFFFF_FFFF_8000_1000.
- rd = 0 with AUIPC, pc = 32'h100, imm20 = 1 -> out_rd_value = 0, out_valid still asserted.
- PIPE_STAGES = 2, out_ready held 0 for 4 cycles while streaming 3 ops -> in_ready drops after 2 accepted, outputs are stable, then all 3 emerge in order once out_ready = 1, with no loss or duplication.
- flush asserted with 2 ops in flight plus in_valid high -> next cycle out_valid = 0, nothing from those 3 ops ever appears. reset_n pulsed low mid-stream -> outputs 0 immediately, asynchronously.
- PERF_EN defined: 5 LUI and 2 AUIPC transfers plus 1 flushed op -> perf_lui_count = 5, perf_auipc_count = 2.
